// File: rtl/convolutional.sv
// Sequential 2-D dilated convolution layer with zero padding and one MAC per clock.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         pulse to begin a full layer pass (ignored while busy or with done)
//   input_data    [IN_DEPTH][IN_HEIGHT][IN_WIDTH] signed feature map, read live
//   kernels       [K][K][IN_DEPTH][OUT_DEPTH] signed filter taps, read live
//   biases        [OUT_DEPTH] signed per-filter bias, read live
//   output_data   [OUT_DEPTH][IN_HEIGHT][IN_WIDTH] registered saturated results
//   busy          high while a pass is in flight
//   done          one-cycle pulse once output_data is complete
module convolutional #(
  parameter int unsigned IN_DEPTH    = 2,
  parameter int unsigned IN_HEIGHT   = 5,
  parameter int unsigned IN_WIDTH    = 5,
  parameter int unsigned OUT_DEPTH   = 32,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned DATA_W      = 18,
  parameter int unsigned FRAC        = 9,
  parameter int unsigned DILATION    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] input_data  [IN_DEPTH][IN_HEIGHT][IN_WIDTH],
  input  logic signed [DATA_W-1:0] kernels     [KERNEL_SIZE][KERNEL_SIZE][IN_DEPTH][OUT_DEPTH],
  input  logic signed [DATA_W-1:0] biases      [OUT_DEPTH],
  output logic signed [DATA_W-1:0] output_data [OUT_DEPTH][IN_HEIGHT][IN_WIDTH],
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CI_W   = (IN_DEPTH    > 1) ? $clog2(IN_DEPTH)    : 1;
  localparam int unsigned CO_W   = (OUT_DEPTH   > 1) ? $clog2(OUT_DEPTH)   : 1;
  localparam int unsigned R_W    = (IN_HEIGHT   > 1) ? $clog2(IN_HEIGHT)   : 1;
  localparam int unsigned C_W    = (IN_WIDTH    > 1) ? $clog2(IN_WIDTH)    : 1;
  localparam int unsigned K_W    = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(IN_DEPTH * KERNEL_SIZE * KERNEL_SIZE) + 2;
  localparam int unsigned P      = KERNEL_SIZE / 2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_e;

  state_e                   state_q, state_d;
  logic [CI_W-1:0]          ci_q, ci_d;
  logic [K_W-1:0]           kh_q, kh_d, kw_q, kw_d;
  logic [CO_W-1:0]          co_q, co_d;
  logic [R_W-1:0]           r_q, r_d;
  logic [C_W-1:0]           c_q, c_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] out_q [OUT_DEPTH][IN_HEIGHT][IN_WIDTH];
  logic signed [DATA_W-1:0] out_d [OUT_DEPTH][IN_HEIGHT][IN_WIDTH];
  logic                     busy_q, busy_d, done_q, done_d;

  logic signed [DATA_W-1:0] pix, kern, res;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum, shifted;
  int                       rr, cc;

  // Tap fetch, MAC datapath, output rounding/saturation and FSM next state
  always_comb begin
    state_d = state_q;
    ci_d    = ci_q;
    kh_d    = kh_q;
    kw_d    = kw_q;
    co_d    = co_q;
    r_d     = r_q;
    c_d     = c_q;
    acc_d   = acc_q;
    out_d   = out_q;
    done_d  = 1'b0;
    pix     = '0;

    // Dilated tap position relative to the current output pixel
    rr = int'(r_q) + (int'(kh_q) - int'(P)) * int'(DILATION);
    cc = int'(c_q) + (int'(kw_q) - int'(P)) * int'(DILATION);
    if (rr >= 0 && rr < int'(IN_HEIGHT) && cc >= 0 && cc < int'(IN_WIDTH)) begin
      pix = input_data[ci_q][R_W'(rr)][C_W'(cc)];
    end
    kern = kernels[kh_q][kw_q][ci_q][co_q];
    prod = PROD_W'(pix) * PROD_W'(kern);

    // Bias joins in the accumulator's fixed-point scale; >>> floors toward -inf
    sum     = acc_q + (ACC_W'(biases[co_q]) <<< FRAC);
    shifted = sum >>> FRAC;
    if (shifted > SAT_MAX) begin
      res = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      res = SAT_MIN[DATA_W-1:0];
    end else begin
      res = shifted[DATA_W-1:0];
    end

    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is not a new request
        if (start && !done_q) begin
          state_d = MAC;
          ci_d = '0; kh_d = '0; kw_d = '0;
          co_d = '0; r_d  = '0; c_d  = '0;
          acc_d = '0;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (kw_q == K_W'(KERNEL_SIZE - 1)) begin
          kw_d = '0;
          if (kh_q == K_W'(KERNEL_SIZE - 1)) begin
            kh_d = '0;
            if (ci_q == CI_W'(IN_DEPTH - 1)) begin
              ci_d    = '0;
              state_d = WRITE;
            end else begin
              ci_d = ci_q + CI_W'(1);
            end
          end else begin
            kh_d = kh_q + K_W'(1);
          end
        end else begin
          kw_d = kw_q + K_W'(1);
        end
      end
      WRITE: begin
        out_d[co_q][r_q][c_q] = res;
        acc_d   = '0;
        state_d = MAC;
        if (c_q == C_W'(IN_WIDTH - 1)) begin
          c_d = '0;
          if (r_q == R_W'(IN_HEIGHT - 1)) begin
            r_d = '0;
            if (co_q == CO_W'(OUT_DEPTH - 1)) begin
              co_d    = '0;
              state_d = DONE;
            end else begin
              co_d = co_q + CO_W'(1);
            end
          end else begin
            r_d = r_q + R_W'(1);
          end
        end else begin
          c_d = c_q + C_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters, accumulator and output map registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ci_q    <= '0;
      kh_q    <= '0;
      kw_q    <= '0;
      co_q    <= '0;
      r_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      out_q   <= '{default: '0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ci_q    <= ci_d;
      kh_q    <= kh_d;
      kw_q    <= kw_d;
      co_q    <= co_d;
      r_q     <= r_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign output_data = out_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_convolutional.sv
// Scoreboard bench for convolutional at default parameters.
module tb_convolutional;

  localparam int ID  = 2;
  localparam int IH  = 5;
  localparam int IW  = 5;
  localparam int OD  = 32;
  localparam int KS  = 3;
  localparam int DW  = 18;
  localparam int FR  = 9;
  localparam int DIL = 2;
  localparam int P   = KS / 2;
  localparam int LAT = OD * IH * IW * (ID * KS * KS + 1) + 1;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic signed [DW-1:0] input_data  [ID][IH][IW];
  logic signed [DW-1:0] kernels     [KS][KS][ID][OD];
  logic signed [DW-1:0] biases      [OD];
  logic signed [DW-1:0] output_data [OD][IH][IW];
  logic busy, done;

  typedef struct {
    int     co;
    int     r;
    int     c;
    longint val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  convolutional #(
    .IN_DEPTH(ID), .IN_HEIGHT(IH), .IN_WIDTH(IW), .OUT_DEPTH(OD),
    .KERNEL_SIZE(KS), .DATA_W(DW), .FRAC(FR), .DILATION(DIL)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .input_data(input_data), .kernels(kernels), .biases(biases),
    .output_data(output_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint golden(input int co, input int r, input int c);
    longint acc;
    acc = longint'(biases[co]) <<< FR;
    for (int ci = 0; ci < ID; ci++)
      for (int kh = 0; kh < KS; kh++)
        for (int kw = 0; kw < KS; kw++) begin
          int y, x;
          y = r + (kh - P) * DIL;
          x = c + (kw - P) * DIL;
          if (y >= 0 && y < IH && x >= 0 && x < IW)
            acc += longint'(input_data[ci][y][x]) * longint'(kernels[kh][kw][ci][co]);
        end
    acc = acc >>> FR;
    if (acc > 131071) acc = 131071;
    if (acc < -131072) acc = -131072;
    return acc;
  endfunction

  task automatic push_model();
    for (int co = 0; co < OD; co++)
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW; c++)
          sb.push_back('{co, r, c, golden(co, r, c)});
  endtask

  task automatic push_const(input longint v);
    for (int co = 0; co < OD; co++)
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW; c++)
          sb.push_back('{co, r, c, v});
  endtask

  task automatic drain(input string name);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s out[%0d][%0d][%0d]", name, e.co, e.r, e.c),
            longint'(output_data[e.co][e.r][e.c]), e.val);
    end
  endtask

  task automatic clear_inputs();
    for (int ci = 0; ci < ID; ci++)
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW; c++) input_data[ci][r][c] = '0;
    for (int kh = 0; kh < KS; kh++)
      for (int kw = 0; kw < KS; kw++)
        for (int ci = 0; ci < ID; ci++)
          for (int co = 0; co < OD; co++) kernels[kh][kw][ci][co] = '0;
    for (int co = 0; co < OD; co++) biases[co] = '0;
  endtask

  // One full pass; optionally re-pulses start mid-run and/or alongside done
  task automatic run_layer(input string name, input int extra_start_at, input bit start_on_done);
    int lat;
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({name, " busy_after_start"}, longint'(busy), 1);
    lat = -1;
    for (int k = 1; k <= LAT + 100 && lat < 0; k++) begin
      @(posedge clk); #1;
      start = (k == extra_start_at);
      if (done) lat = k;
    end
    start = 1'b0;
    if (lat < 0) begin
      check({name, " done_timeout"}, 0, 1);
    end else begin
      check({name, " latency"}, longint'(lat), LAT);
      check({name, " busy_at_done"}, longint'(busy), 0);
    end
    if (start_on_done) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({name, " done_one_cycle"}, longint'(done), 0);
    check({name, " busy_after_done"}, longint'(busy), 0);
    repeat (5) @(posedge clk);
    #1 check({name, " done_pulses"}, longint'(done_cnt - d0), 1);
  endtask

  initial begin
    int v;
    int d0;
    rst = 1'b1;
    start = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("por busy", longint'(busy), 0);
    check("por done", longint'(done), 0);
    push_const(0);
    drain("por");

    // Zero map, bias 1.5, kernels arbitrary; start alongside done must be ignored
    for (int kh = 0; kh < KS; kh++)
      for (int kw = 0; kw < KS; kw++)
        for (int ci = 0; ci < ID; ci++)
          for (int co = 0; co < OD; co++)
            kernels[kh][kw][ci][co] = DW'(int'($urandom_range(0, 4095)) - 2048);
    for (int co = 0; co < OD; co++) biases[co] = DW'(768);
    push_const(768);
    run_layer("zero", 0, 1'b1);
    drain("zero");

    // Impulse at the center of channel 0
    clear_inputs();
    input_data[0][2][2] = DW'(512);
    for (int kh = 0; kh < KS; kh++)
      for (int kw = 0; kw < KS; kw++)
        for (int co = 0; co < OD; co++)
          kernels[kh][kw][0][co] = DW'((3 * kh + kw + 1) * 64);
    push_model();
    run_layer("impulse", 0, 1'b0);
    drain("impulse");
    check("impulse c0 [0][0]",  longint'(output_data[0][0][0]), 576);
    check("impulse c31 [2][2]", longint'(output_data[31][2][2]), 320);
    check("impulse c7 [4][4]",  longint'(output_data[7][4][4]), 64);
    check("impulse c3 [1][3]",  longint'(output_data[3][1][3]), 0);

    // Saturation: even filters positive, odd filters negated
    for (int ci = 0; ci < ID; ci++)
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW; c++) input_data[ci][r][c] = DW'(51200);
    for (int kh = 0; kh < KS; kh++)
      for (int kw = 0; kw < KS; kw++)
        for (int ci = 0; ci < ID; ci++)
          for (int co = 0; co < OD; co++)
            kernels[kh][kw][ci][co] = (co % 2 == 0) ? DW'(5120) : DW'(-5120);
    for (int co = 0; co < OD; co++) biases[co] = '0;
    push_model();
    run_layer("sat", 0, 1'b0);
    drain("sat");
    check("sat pos center", longint'(output_data[0][2][2]), 131071);
    check("sat neg center", longint'(output_data[1][2][2]), -131072);

    // Reset 100 cycles into a run aborts it and clears the map
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("reset busy", longint'(busy), 0);
    check("reset done", longint'(done), 0);
    push_const(0);
    drain("reset");
    repeat (40) @(posedge clk);
    #1 check("reset no done", longint'(done_cnt - d0), 0);
    check("reset idle busy", longint'(busy), 0);

    // Random vectors with truncation probes on filter 0 and a start while busy
    for (int ci = 0; ci < ID; ci++)
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW; c++)
          input_data[ci][r][c] = DW'(int'($urandom_range(0, 8191)) - 4096);
    for (int kh = 0; kh < KS; kh++)
      for (int kw = 0; kw < KS; kw++)
        for (int ci = 0; ci < ID; ci++)
          for (int co = 0; co < OD; co++) begin
            v = int'($urandom_range(0, 2047)) - 1024;
            kernels[kh][kw][ci][co] = (co == 0) ? DW'(0) : DW'(v);
          end
    for (int co = 0; co < OD; co++)
      biases[co] = (co == 0) ? DW'(0) : DW'(int'($urandom_range(0, 65535)) - 32768);
    kernels[1][1][0][0] = DW'(256);
    input_data[0][0][0] = DW'(1);
    input_data[0][0][1] = DW'(-1);
    push_model();
    run_layer("random", 50, 1'b0);
    drain("random");
    check("trunc +1", longint'(output_data[0][0][0]), 0);
    check("trunc -1", longint'(output_data[0][0][1]), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
